axis_pkt_arbiter: RTL and testbench

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

---
 rtl/axis_pkt_arbiter.sv | 172 +++++++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arbiter.sv
// Two-input AXI-Stream packet arbiter: round-robin ownership per packet, zero-latency
// forwarding to the packet FIFO, and word-limit truncation with drain of the remainder.
module axis_pkt_arbiter #(
   parameter int C_AXIS_TDATA_WIDTH = 32,
   parameter int C_MAX_PKT_WORDS    = 80
) (
   input  logic                              axis_aclk,
   input  logic                              axis_aresetn,
   input  logic                              s00_axis_tvalid,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
   input  logic                              s00_axis_tlast,
   output logic                              s00_axis_tready,
   input  logic                              s01_axis_tvalid,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]     s01_axis_tdata,
   input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s01_axis_tstrb,
   input  logic                              s01_axis_tlast,
   output logic                              s01_axis_tready,
   output logic                              m00_axis_tvalid,
   output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
   output logic                              m00_axis_tlast,
   input  logic                              m00_axis_tready,
   output logic [1:0]                        grant,
   output logic                              trunc_pulse
);

   function automatic int clogb2(input int value);
      int depth_v;
      int bits_v;
      depth_v = value;
      bits_v  = 0;
      while (depth_v > 0) begin
         bits_v  = bits_v + 1;
         depth_v = depth_v >> 1;
      end
      return bits_v;
   endfunction

   localparam int               CNT_W    = clogb2(C_MAX_PKT_WORDS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(C_MAX_PKT_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FWD   = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   state_t                          state_r;
   logic [CNT_W-1:0]                word_cnt_r;
   logic                            last_grant_r;
   logic [1:0]                      grant_r;
   logic                            trunc_pulse_r;

   logic                            owner_s;
   logic                            src_valid_s;
   logic [C_AXIS_TDATA_WIDTH-1:0]   src_data_s;
   logic [C_AXIS_TDATA_WIDTH/8-1:0] src_strb_s;
   logic                            src_last_s;
   logic                            limit_s;
   logic                            fwd_s;
   logic                            drain_s;

   // Owner's stream: the upper grant bit is the owning port index.
   always_comb begin
      owner_s = grant_r[1];
      if (owner_s) begin
         src_valid_s = s01_axis_tvalid;
         src_data_s  = s01_axis_tdata;
         src_strb_s  = s01_axis_tstrb;
         src_last_s  = s01_axis_tlast;
      end else begin
         src_valid_s = s00_axis_tvalid;
         src_data_s  = s00_axis_tdata;
         src_strb_s  = s00_axis_tstrb;
         src_last_s  = s00_axis_tlast;
      end
   end

   // A low reset blocks the datapath in the same cycle so no beat of an abandoned packet slips out.
   assign limit_s = (word_cnt_r == LAST_IDX);
   assign fwd_s   = (state_r == ST_FWD) && axis_aresetn;
   assign drain_s = (state_r == ST_DRAIN) && axis_aresetn;

   // Zero-latency mirror of the owner onto the master port, and tready routing back to the owner.
   always_comb begin
      m00_axis_tvalid = 1'b0;
      m00_axis_tdata  = '0;
      m00_axis_tstrb  = '0;
      m00_axis_tlast  = 1'b0;
      s00_axis_tready = 1'b0;
      s01_axis_tready = 1'b0;
      if (fwd_s) begin
         m00_axis_tvalid = src_valid_s;
         m00_axis_tdata  = src_data_s;
         m00_axis_tstrb  = src_strb_s;
         m00_axis_tlast  = src_valid_s && (src_last_s || limit_s);
         if (owner_s) begin
            s01_axis_tready = m00_axis_tready;
         end else begin
            s00_axis_tready = m00_axis_tready;
         end
      end else if (drain_s) begin
         if (owner_s) begin
            s01_axis_tready = 1'b1;
         end else begin
            s00_axis_tready = 1'b1;
         end
      end else begin
         m00_axis_tvalid = 1'b0;
         m00_axis_tlast  = 1'b0;
      end
   end

   // Packet ownership state machine: arbitration, word counting, truncation and drain.
   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         state_r       <= ST_IDLE;
         word_cnt_r    <= '0;
         last_grant_r  <= 1'b1;
         grant_r       <= 2'b00;
         trunc_pulse_r <= 1'b0;
      end else begin
         trunc_pulse_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // s00 wins when alone, or on a tie when s01 owned the previous packet.
               if (s00_axis_tvalid && (!s01_axis_tvalid || last_grant_r)) begin
                  grant_r    <= 2'b01;
                  word_cnt_r <= '0;
                  state_r    <= ST_FWD;
               end else if (s01_axis_tvalid) begin
                  grant_r    <= 2'b10;
                  word_cnt_r <= '0;
                  state_r    <= ST_FWD;
               end else begin
                  grant_r    <= 2'b00;
               end
            end
            ST_FWD: begin
               if (src_valid_s && m00_axis_tready) begin
                  if (src_last_s) begin
                     state_r      <= ST_IDLE;
                     grant_r      <= 2'b00;
                     last_grant_r <= owner_s;
                  end else if (limit_s) begin
                     state_r       <= ST_DRAIN;
                     trunc_pulse_r <= 1'b1;
                  end else begin
                     word_cnt_r <= word_cnt_r + CNT_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (src_valid_s && src_last_s) begin
                  state_r      <= ST_IDLE;
                  grant_r      <= 2'b00;
                  last_grant_r <= owner_s;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               grant_r <= 2'b00;
            end
         endcase
      end
   end

   assign grant       = grant_r;
   assign trunc_pulse = trunc_pulse_r;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: directed packet table, reset corner case,
// and randomized traffic scored against a packet-level reference model.
module tb_axis_pkt_arbiter;
   localparam int W    = 32;
   localparam int MAXW = 80;

   logic           axis_aclk = 1'b0;
   logic           axis_aresetn;
   logic           sv [2];
   logic [W-1:0]   sd [2];
   logic [W/8-1:0] ss [2];
   logic           sl [2];
   logic           st0, st1;
   logic           m_tvalid, m_tlast, m_tready;
   logic [W-1:0]   m_tdata;
   logic [W/8-1:0] m_tstrb;
   logic [1:0]     grant;
   logic           trunc_pulse;

   int tests = 0;
   int fails = 0;

   // Packet model: each packet is {id, len} packed as id*256+len; words are tagged by port/id/index.
   int src_q0[$], src_q1[$], exp_q0[$], exp_q1[$];
   bit busy [2];
   bit hs [2];
   int cur [2];
   int idx [2];
   int next_id [2];
   bit out_act;
   int out_p, out_idx;
   int beats, first_port, trunc_seen, trunc_exp;
   int valid_pct, rdy_mode;

   axis_pkt_arbiter #(.C_AXIS_TDATA_WIDTH(W), .C_MAX_PKT_WORDS(MAXW)) dut (
      .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
      .s00_axis_tvalid(sv[0]), .s00_axis_tdata(sd[0]), .s00_axis_tstrb(ss[0]),
      .s00_axis_tlast(sl[0]), .s00_axis_tready(st0),
      .s01_axis_tvalid(sv[1]), .s01_axis_tdata(sd[1]), .s01_axis_tstrb(ss[1]),
      .s01_axis_tlast(sl[1]), .s01_axis_tready(st1),
      .m00_axis_tvalid(m_tvalid), .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb),
      .m00_axis_tlast(m_tlast), .m00_axis_tready(m_tready),
      .grant(grant), .trunc_pulse(trunc_pulse)
   );

   always #5 axis_aclk = ~axis_aclk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] word_of(input int p, input int id, input int i);
      return {p[0], id[14:0], i[15:0]};
   endfunction

   function automatic logic [W/8-1:0] strb_of(input int i);
      return i[3:0] | 4'h1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic queue_pkt(input int p, input int len);
      int pkt;
      pkt = (next_id[p] << 8) | len;
      next_id[p]++;
      if (len > MAXW) trunc_exp++;
      if (p == 0) begin src_q0.push_back(pkt); exp_q0.push_back(pkt); end
      else begin src_q1.push_back(pkt); exp_q1.push_back(pkt); end
   endtask

   task automatic clear_model();
      src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete();
      for (int p = 0; p < 2; p++) begin
         busy[p] = 1'b0; hs[p] = 1'b0; sv[p] = 1'b0; sl[p] = 1'b0; idx[p] = 0;
      end
      out_act = 1'b0; out_idx = 0;
   endtask

   // Negedge sampling: handshakes, truncation pulses and the output scoreboard.
   task automatic sample();
      int p, pkt, len, id;
      bit exp_last;
      @(negedge axis_aclk);
      hs[0] = sv[0] && st0;
      hs[1] = sv[1] && st1;
      if (trunc_pulse) trunc_seen++;
      if (!m_tvalid) begin
         check("tlast_without_tvalid", m_tlast, 1'b0);
      end else begin
         p = out_act ? out_p : int'(m_tdata[W-1]);
         if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            check("spurious_beat", m_tvalid, 1'b0);
         end else begin
            pkt = (p == 0) ? exp_q0[0] : exp_q1[0];
            id = pkt >> 8;
            len = pkt & 255;
            exp_last = (out_idx == len - 1) || (out_idx == MAXW - 1);
            check("tdata", m_tdata, word_of(p, id, out_idx));
            check("tstrb", m_tstrb, strb_of(out_idx));
            check("tlast", m_tlast, exp_last);
            check("grant_fwd", grant, (p == 1) ? 2'b10 : 2'b01);
            check("owner_tready", p ? st1 : st0, m_tready);
            check("other_tready", p ? st0 : st1, 1'b0);
            if (m_tready) begin
               if (!out_act) begin
                  out_act = 1'b1;
                  out_p = p;
                  if (first_port < 0) first_port = p;
               end
               beats++;
               if (exp_last) begin
                  out_act = 1'b0;
                  out_idx = 0;
                  if (p == 0) void'(exp_q0.pop_front());
                  else void'(exp_q1.pop_front());
               end else begin
                  out_idx++;
               end
            end
         end
      end
   endtask

   // Source drivers and master tready, updated just after the clock edge.
   task automatic drive();
      @(posedge axis_aclk);
      #1;
      for (int p = 0; p < 2; p++) begin
         if (hs[p]) begin
            idx[p]++;
            if (idx[p] == (cur[p] & 255)) busy[p] = 1'b0;
         end
         if (hs[p] || !sv[p]) begin
            if (!busy[p] && ((p == 0) ? src_q0.size() : src_q1.size()) > 0) begin
               if (p == 0) cur[p] = src_q0.pop_front();
               else cur[p] = src_q1.pop_front();
               idx[p] = 0;
               busy[p] = 1'b1;
            end
            sv[p] = busy[p] && (int'($urandom_range(0, 99)) < valid_pct);
            sd[p] = word_of(p, cur[p] >> 8, idx[p]);
            ss[p] = strb_of(idx[p]);
            sl[p] = (idx[p] == (cur[p] & 255) - 1);
         end
      end
      case (rdy_mode)
         0: m_tready = 1'b1;
         1: m_tready = ~m_tready;
         default: m_tready = ($urandom_range(0, 99) < 70);
      endcase
   endtask

   task automatic do_reset();
      axis_aresetn = 1'b0;
      sv[0] = 1'b1; sv[1] = 1'b1; sl[0] = 1'b1; sl[1] = 1'b1;
      m_tready = 1'b1;
      repeat (2) @(posedge axis_aclk);
      @(negedge axis_aclk);
      check("rst_grant", grant, 2'b00);
      check("rst_trunc", trunc_pulse, 1'b0);
      check("rst_m_tvalid", m_tvalid, 1'b0);
      check("rst_m_tlast", m_tlast, 1'b0);
      check("rst_s00_tready", st0, 1'b0);
      check("rst_s01_tready", st1, 1'b0);
      clear_model();
      @(posedge axis_aclk);
      #1;
      axis_aresetn = 1'b1;
   endtask

   task automatic run_until_idle(input int bound);
      int n;
      n = 0;
      while ((busy[0] || busy[1] || src_q0.size() > 0 || src_q1.size() > 0 || out_act) && n < bound) begin
         sample();
         drive();
         n++;
      end
      check("cycle_budget_exceeded", n >= bound, 1'b0);
      repeat (2) begin sample(); drive(); end
      sample();
      check("idle_grant", grant, 2'b00);
      check("idle_m_tvalid", m_tvalid, 1'b0);
      drive();
   endtask

   typedef struct {
      bit rst; int len0; int len1; int rmode; int exp_first; int exp_beats; int exp_trunc;
   } vec_t;
   vec_t vecs [8];

   initial begin
      vecs[0] = '{1'b1, 4,  0,  0, 0, 4,  0};   // single source
      vecs[1] = '{1'b1, 3,  3,  0, 0, 6,  0};   // tie from reset: s00 first
      vecs[2] = '{1'b0, 3,  3,  0, 0, 6,  0};   // next tie alternates back to s00
      vecs[3] = '{1'b1, 5,  0,  1, 0, 5,  0};   // toggling backpressure
      vecs[4] = '{1'b1, 0,  83, 0, 1, 80, 1};   // truncation with 3-word drain
      vecs[5] = '{1'b1, 80, 0,  0, 0, 80, 0};   // tlast exactly at the limit
      vecs[6] = '{1'b1, 81, 0,  1, 0, 80, 1};   // one word over, with backpressure
      vecs[7] = '{1'b1, 0,  79, 0, 1, 79, 0};   // one word under

      axis_aresetn = 1'b0;
      m_tready = 1'b1;
      valid_pct = 100;
      rdy_mode = 0;
      next_id[0] = 0; next_id[1] = 0;
      for (int p = 0; p < 2; p++) begin sd[p] = '0; ss[p] = '0; end
      clear_model();

      for (int v = 0; v < 8; v++) begin
         if (vecs[v].rst) do_reset();
         beats = 0; first_port = -1; trunc_seen = 0; trunc_exp = 0;
         rdy_mode = vecs[v].rmode;
         if (vecs[v].len0 > 0) queue_pkt(0, vecs[v].len0);
         if (vecs[v].len1 > 0) queue_pkt(1, vecs[v].len1);
         run_until_idle(2000);
         check($sformatf("vec%0d_first_port", v), first_port, vecs[v].exp_first);
         check($sformatf("vec%0d_beats", v), beats, vecs[v].exp_beats);
         check($sformatf("vec%0d_trunc", v), trunc_seen, vecs[v].exp_trunc);
      end

      // Reset after beat 2 of a 6-word packet abandons it; a fresh packet then forwards normally.
      do_reset();
      rdy_mode = 0; beats = 0; first_port = -1;
      queue_pkt(0, 6);
      for (int n = 0; n < 50 && beats < 2; n++) begin sample(); drive(); end
      check("midrst_beats_before", beats, 2);
      axis_aresetn = 1'b0;
      @(negedge axis_aclk);
      check("midrst_m_tvalid_now", m_tvalid, 1'b0);
      check("midrst_s00_tready_now", st0, 1'b0);
      @(negedge axis_aclk);
      check("midrst_grant", grant, 2'b00);
      check("midrst_s00_tready", st0, 1'b0);
      check("midrst_s01_tready", st1, 1'b0);
      check("midrst_m_tvalid", m_tvalid, 1'b0);
      clear_model();
      @(posedge axis_aclk);
      #1;
      axis_aresetn = 1'b1;
      beats = 0; first_port = -1; trunc_seen = 0; trunc_exp = 0;
      queue_pkt(1, 3);
      run_until_idle(200);
      check("midrst_fresh_beats", beats, 3);
      check("midrst_fresh_port", first_port, 1);

      // Randomized traffic on both ports with random gaps and backpressure.
      do_reset();
      valid_pct = 70; rdy_mode = 2;
      beats = 0; first_port = -1; trunc_seen = 0; trunc_exp = 0;
      for (int k = 0; k < 25; k++) begin
         for (int p = 0; p < 2; p++) begin
            if ($urandom_range(0, 9) == 0) queue_pkt(p, int'($urandom_range(78, 84)));
            else queue_pkt(p, int'($urandom_range(1, 10)));
         end
      end
      run_until_idle(40000);
      check("rand_trunc_count", trunc_seen, trunc_exp);
      check("rand_exp_q0_empty", exp_q0.size(), 0);
      check("rand_exp_q1_empty", exp_q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
